// File: rtl/mem_pkg.sv
// Shared definitions for the block-addressed main-memory model behind the data cache.
package mem_pkg;
    localparam int ADDR_W     = 10;
    localparam int BLOCK_W    = 128;
    localparam int NUM_BLOCKS = 64;
    localparam int IDX_W      = 6;
    localparam int IDX_LSB    = 4;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;
endpackage

// File: rtl/mem_block_array.sv
// 64 x 128-bit block storage: synchronous write, asynchronous read by block index.
module mem_block_array
    import mem_pkg::*;
(
    input  logic               clk,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   waddr_i,
    input  logic [BLOCK_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]   raddr_i,
    output logic [BLOCK_W-1:0] rdata_o
);
    // Contents start at zero and are deliberately untouched by reset.
    logic [BLOCK_W-1:0] mem_q [NUM_BLOCKS] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/cache_main_memory.sv
// Fixed-latency main-memory model servicing whole-block reads and write-throughs for the cache.
module cache_main_memory
    import mem_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic               read_cache,
    input  logic [ADDR_W-1:0]  addr_cache,
    input  logic [BLOCK_W-1:0] WriteData_cache,
    output logic [BLOCK_W-1:0] ReadData_mem,
    output logic               ready,
    output logic               busy,
    output logic [1:0]         state_o
);
    // Handshake: req is a level sampled only in IDLE; acceptance latches op, index and data.
    // ready is a one-cycle registered pulse; busy covers acceptance through the ready cycle.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BLOCK_W-1:0] wdata_q, wdata_d;
    logic [BLOCK_W-1:0] rdata_q, rdata_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               mem_we;
    logic [BLOCK_W-1:0] mem_rdata;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^addr_cache[IDX_LSB-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    op_d    = read_cache;
                    idx_d   = addr_cache[ADDR_W-1:IDX_LSB];
                    wdata_d = WriteData_cache;
                    cnt_d   = CNT_INIT;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    // A reset on the commit edge must suppress the array write too.
                    if (op_q == OP_WRITE) begin
                        mem_we = ~reset;
                    end else begin
                        rdata_d = mem_rdata;
                    end
                    ready_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                ready_d = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_READ;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    mem_block_array u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .raddr_i (idx_q),
        .rdata_o (mem_rdata)
    );

    assign ReadData_mem = rdata_q;
    assign ready        = ready_q;
    assign busy         = busy_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_cache_main_memory.sv
// Directed bench for cache_main_memory at LATENCY=4 and LATENCY=1.
module tb_cache_main_memory;
    import mem_pkg::*;

    logic         clk = 1'b0;
    logic         reset, req, read_cache;
    logic [9:0]   addr_cache;
    logic [127:0] WriteData_cache, ReadData_mem;
    logic         ready, busy;
    logic [1:0]   state_o;

    logic         reset1, req1, read_cache1;
    logic [9:0]   addr_cache1;
    logic [127:0] WriteData_cache1, ReadData_mem1;
    logic         ready1, busy1;
    logic [1:0]   state1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cache_main_memory #(.LATENCY(4)) dut (
        .clk(clk), .reset(reset), .req(req), .read_cache(read_cache),
        .addr_cache(addr_cache), .WriteData_cache(WriteData_cache),
        .ReadData_mem(ReadData_mem), .ready(ready), .busy(busy), .state_o(state_o)
    );

    cache_main_memory #(.LATENCY(1)) dut1 (
        .clk(clk), .reset(reset1), .req(req1), .read_cache(read_cache1),
        .addr_cache(addr_cache1), .WriteData_cache(WriteData_cache1),
        .ReadData_mem(ReadData_mem1), .ready(ready1), .busy(busy1), .state_o(state1)
    );

    localparam logic [127:0] PAT_D  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] PAT_4  = 128'h4444_0000_1111_2222_3333_4444_5555_0004;
    localparam logic [127:0] PAT_8  = 128'h8888_0000_AAAA_BBBB_CCCC_DDDD_EEEE_0008;
    localparam logic [127:0] ONES   = {128{1'b1}};
    localparam logic [127:0] PAT_Q  = 128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_1234_5678;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete access on the LATENCY=4 instance; req is up for exactly one edge.
    task automatic run_access(input string tag, input logic op, input logic [9:0] a,
                              input logic [127:0] wd, input logic [127:0] exp_rd);
        int k;
        req = 1'b1; read_cache = op; addr_cache = a; WriteData_cache = wd;
        step();
        req = 1'b0;
        check({tag, "_busy_accept"}, busy, 1);
        k = 0;
        while (ready !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check({tag, "_latency"}, k, 4);
        check({tag, "_rdata"}, ReadData_mem, exp_rd);
        step();
        check({tag, "_idle_after"}, {ready, busy}, 2'b00);
    endtask

    initial begin
        logic [127:0] seq_data [6];
        logic [9:0]   seq_addr [6];
        logic         seq_op   [6];
        logic [127:0] seq_exp  [6];
        int pulses, cyc, late;

        reset = 1'b1; req = 1'b0; read_cache = 1'b0; addr_cache = '0; WriteData_cache = '0;
        reset1 = 1'b1; req1 = 1'b0; read_cache1 = 1'b0; addr_cache1 = '0; WriteData_cache1 = '0;
        step();
        step();
        reset = 1'b0;
        reset1 = 1'b0;
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata", ReadData_mem, 0);
        check("rst_state", state_o, 128'(ST_IDLE));

        // First read: check each edge explicitly.
        req = 1'b1; read_cache = OP_READ; addr_cache = 10'h000;
        step();
        req = 1'b0;
        check("rd0_e0_state", state_o, 128'(ST_WAIT));
        check("rd0_e0_busy", {ready, busy}, 2'b01);
        step(); step(); step();
        check("rd0_e3_ready", {ready, busy}, 2'b01);
        step();
        check("rd0_e4_ready", {ready, busy}, 2'b11);
        check("rd0_e4_rdata", ReadData_mem, 0);
        step();
        check("rd0_e5_idle", {ready, busy}, 2'b00);
        check("rd0_e5_state", state_o, 128'(ST_IDLE));

        // Write, then read back through a different byte offset of block 58.
        run_access("wr_3a5", OP_WRITE, 10'h3A5, PAT_D, 128'h0);
        run_access("rd_3a0", OP_READ, 10'h3A0, '0, PAT_D);

        // Inputs changed during WAIT must be ignored.
        run_access("wr_040", OP_WRITE, 10'h040, PAT_4, PAT_D);
        run_access("wr_080", OP_WRITE, 10'h080, PAT_8, PAT_D);
        req = 1'b1; read_cache = OP_READ; addr_cache = 10'h040; WriteData_cache = '0;
        step();
        req = 1'b0; read_cache = OP_WRITE; addr_cache = 10'h080; WriteData_cache = ONES;
        cyc = 0;
        while (ready !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        check("chg_latency", cyc, 4);
        check("chg_rdata_blk4", ReadData_mem, PAT_4);
        step();
        run_access("chg_blk8", OP_READ, 10'h080, '0, PAT_8);

        // req held high: alternating writes and reads, one completion every 6 cycles.
        seq_op[0] = OP_WRITE; seq_addr[0] = 10'h200; seq_data[0] = 128'h1;   seq_exp[0] = PAT_8;
        seq_op[1] = OP_READ;  seq_addr[1] = 10'h200; seq_data[1] = '0;      seq_exp[1] = 128'h1;
        seq_op[2] = OP_WRITE; seq_addr[2] = 10'h210; seq_data[2] = PAT_Q;   seq_exp[2] = 128'h1;
        seq_op[3] = OP_READ;  seq_addr[3] = 10'h21F; seq_data[3] = '0;      seq_exp[3] = PAT_Q;
        seq_op[4] = OP_WRITE; seq_addr[4] = 10'h200; seq_data[4] = PAT_D;   seq_exp[4] = PAT_Q;
        seq_op[5] = OP_READ;  seq_addr[5] = 10'h208; seq_data[5] = '0;      seq_exp[5] = PAT_D;
        pulses = 0; cyc = 0;
        req = 1'b1; read_cache = seq_op[0]; addr_cache = seq_addr[0]; WriteData_cache = seq_data[0];
        while (pulses < 6 && cyc < 80) begin
            step();
            cyc++;
            if (ready === 1'b1) begin
                check($sformatf("stream_cycle_%0d", pulses), cyc, 5 + 6 * pulses);
                check($sformatf("stream_rdata_%0d", pulses), ReadData_mem, seq_exp[pulses]);
                pulses++;
                if (pulses < 6) begin
                    read_cache = seq_op[pulses]; addr_cache = seq_addr[pulses];
                    WriteData_cache = seq_data[pulses];
                end else begin
                    req = 1'b0;
                end
            end
        end
        check("stream_pulses", pulses, 6);
        req = 1'b0;
        late = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ready === 1'b1) late++;
        end
        check("stream_no_extra", late, 0);

        // Reset at edge 2 of a write aborts it.
        req = 1'b1; read_cache = OP_WRITE; addr_cache = 10'h100; WriteData_cache = ONES;
        step();
        req = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_outputs", {ready, busy}, 2'b00);
        check("abort_state", state_o, 128'(ST_IDLE));
        check("abort_rdata", ReadData_mem, 0);
        late = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ready === 1'b1 || busy === 1'b1) late++;
        end
        check("abort_quiet", late, 0);
        run_access("abort_rd_100", OP_READ, 10'h100, '0, 128'h0);

        // LATENCY=1 instance.
        req1 = 1'b1; read_cache1 = OP_READ; addr_cache1 = 10'h000;
        step();
        req1 = 1'b0;
        check("l1_e0", {ready1, busy1}, 2'b01);
        step();
        check("l1_e1", {ready1, busy1}, 2'b11);
        check("l1_e1_rdata", ReadData_mem1, 0);
        step();
        check("l1_e2", {ready1, busy1}, 2'b00);

        req1 = 1'b1; read_cache1 = OP_WRITE; addr_cache1 = 10'h030; WriteData_cache1 = PAT_Q;
        step(); req1 = 1'b0; step(); step();
        req1 = 1'b1; read_cache1 = OP_READ; addr_cache1 = 10'h030; WriteData_cache1 = '0;
        step(); req1 = 1'b0; step();
        check("l1_wr_rd_030", ReadData_mem1, PAT_Q);
        step();

        // Reset on the commit edge must leave block 2 untouched.
        req1 = 1'b1; read_cache1 = OP_WRITE; addr_cache1 = 10'h020; WriteData_cache1 = ONES;
        step();
        req1 = 1'b0;
        reset1 = 1'b1;
        step();
        reset1 = 1'b0;
        check("l1_rstcommit_out", {ready1, busy1}, 2'b00);
        req1 = 1'b1; read_cache1 = OP_READ; addr_cache1 = 10'h020;
        step(); req1 = 1'b0; step();
        check("l1_rstcommit_ready", ready1, 1);
        check("l1_rstcommit_rdata", ReadData_mem1, 0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
